// File: rtl/ysyx_041514_csr_file.sv
// Machine-mode CSR register file: combinational CSR-instruction reads, instruction and
// trap-port writes with field masking, and the mcycle/minstret counters.
module ysyx_041514_csr_file #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr_i,
  input  logic            csr_re_i,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic [11:0]     csr_waddr_i,
  input  logic            csr_we_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_illegal_o,
  input  logic [XLEN-1:0] csr_mstatus_writedata_i,
  input  logic [XLEN-1:0] csr_mepc_writedata_i,
  input  logic [XLEN-1:0] csr_mcause_writedata_i,
  input  logic [XLEN-1:0] csr_mtval_writedata_i,
  input  logic [XLEN-1:0] csr_mip_writedata_i,
  input  logic            csr_mstatus_write_valid_i,
  input  logic            csr_mepc_write_valid_i,
  input  logic            csr_mcause_write_valid_i,
  input  logic            csr_mtval_write_valid_i,
  input  logic            csr_mip_write_valid_i,
  output logic [XLEN-1:0] csr_mstatus_readdata_o,
  output logic [XLEN-1:0] csr_mepc_readdata_o,
  output logic [XLEN-1:0] csr_mtvec_readdata_o,
  output logic [XLEN-1:0] csr_mip_readdata_o,
  output logic [XLEN-1:0] csr_mie_readdata_o,
  input  logic            instret_i
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(64'h1888);  // MPP, MPIE, MIE
  localparam logic [XLEN-1:0] MIE_MASK     = XLEN'(64'h0888);
  localparam logic [XLEN-1:0] MIP_MASK     = XLEN'(64'h0080);  // MTIP only
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(64'h3);
  localparam logic [XLEN-1:0] MISA_VALUE   = XLEN'(64'h8000_0000_0000_1100);

  logic [XLEN-1:0] mstatus_q,  mstatus_d;
  logic [XLEN-1:0] mie_q,      mie_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mtval_q,    mtval_d;
  logic [XLEN-1:0] mip_q,      mip_d;
  logic [XLEN-1:0] mcycle_q,   mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic raddr_impl;
  logic waddr_impl;
  logic waddr_ro;
  logic inst_we;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    csr_rdata_o = '0;
    raddr_impl  = 1'b1;
    case (csr_raddr_i)
      ADDR_MSTATUS:              csr_rdata_o = mstatus_q;
      ADDR_MISA:                 csr_rdata_o = MISA_VALUE;
      ADDR_MIE:                  csr_rdata_o = mie_q;
      ADDR_MTVEC:                csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH:             csr_rdata_o = mscratch_q;
      ADDR_MEPC:                 csr_rdata_o = mepc_q;
      ADDR_MCAUSE:               csr_rdata_o = mcause_q;
      ADDR_MTVAL:                csr_rdata_o = mtval_q;
      ADDR_MIP:                  csr_rdata_o = mip_q;
      ADDR_MCYCLE, ADDR_CYCLE:   csr_rdata_o = mcycle_q;
      ADDR_MINSTRET, ADDR_INSTRET: csr_rdata_o = minstret_q;
      ADDR_MHARTID:              csr_rdata_o = '0;
      default:                   raddr_impl  = 1'b0;
    endcase
  end

  always_comb begin
    waddr_impl = 1'b0;
    waddr_ro   = 1'b0;
    case (csr_waddr_i)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET: begin
        waddr_impl = 1'b1;
      end
      ADDR_MISA, ADDR_CYCLE, ADDR_INSTRET, ADDR_MHARTID: begin
        waddr_impl = 1'b1;
        waddr_ro   = 1'b1;
      end
      default: begin
        waddr_impl = 1'b0;
        waddr_ro   = 1'b0;
      end
    endcase
  end

  assign csr_illegal_o = (csr_re_i & ~raddr_impl) | (csr_we_i & (~waddr_impl | waddr_ro));
  assign inst_we       = csr_we_i & waddr_impl & ~waddr_ro;

  // Trap-port strobe beats instruction write, which beats the counter increment.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = mip_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = instret_i ? minstret_q + XLEN'(1) : minstret_q;

    if (inst_we) begin
      case (csr_waddr_i)
        ADDR_MSTATUS:  mstatus_d  = csr_wdata_i & MSTATUS_MASK;
        ADDR_MIE:      mie_d      = csr_wdata_i & MIE_MASK;
        ADDR_MTVEC:    mtvec_d    = csr_wdata_i & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
        ADDR_MEPC:     mepc_d     = csr_wdata_i & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
        ADDR_MTVAL:    mtval_d    = csr_wdata_i;
        ADDR_MCYCLE:   mcycle_d   = csr_wdata_i;
        ADDR_MINSTRET: minstret_d = csr_wdata_i;
        default:       mip_d      = mip_q;  // mip is trap-owned; instruction writes drop
      endcase
    end

    if (csr_mstatus_write_valid_i) mstatus_d = csr_mstatus_writedata_i & MSTATUS_MASK;
    if (csr_mepc_write_valid_i)    mepc_d    = csr_mepc_writedata_i & ALIGN_MASK;
    if (csr_mcause_write_valid_i)  mcause_d  = csr_mcause_writedata_i;
    if (csr_mtval_write_valid_i)   mtval_d   = csr_mtval_writedata_i;
    if (csr_mip_write_valid_i)     mip_d     = csr_mip_writedata_i & MIP_MASK;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its
  // pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign csr_mstatus_readdata_o = mstatus_q;
  assign csr_mepc_readdata_o    = mepc_q;
  assign csr_mtvec_readdata_o   = mtvec_q;
  assign csr_mip_readdata_o     = mip_q;
  assign csr_mie_readdata_o     = mie_q;

endmodule

// File: tb/tb_ysyx_041514_csr_file.sv
// Bench for ysyx_041514_csr_file: directed scenarios plus a randomized run, all checked
// against an address-indexed behavioural model of the CSR space.
module tb_ysyx_041514_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_raddr_i = '0;
  logic        csr_re_i = 1'b0;
  logic [63:0] csr_rdata_o;
  logic [11:0] csr_waddr_i = '0;
  logic        csr_we_i = 1'b0;
  logic [63:0] csr_wdata_i = '0;
  logic        csr_illegal_o;
  logic [63:0] mstatus_wd = '0, mepc_wd = '0, mcause_wd = '0, mtval_wd = '0, mip_wd = '0;
  logic        mstatus_wv = 1'b0, mepc_wv = 1'b0, mcause_wv = 1'b0, mtval_wv = 1'b0, mip_wv = 1'b0;
  logic [63:0] mstatus_rd, mepc_rd, mtvec_rd, mip_rd, mie_rd;
  logic        instret_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_041514_csr_file #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .csr_raddr_i(csr_raddr_i), .csr_re_i(csr_re_i), .csr_rdata_o(csr_rdata_o),
    .csr_waddr_i(csr_waddr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
    .csr_illegal_o(csr_illegal_o),
    .csr_mstatus_writedata_i(mstatus_wd), .csr_mepc_writedata_i(mepc_wd),
    .csr_mcause_writedata_i(mcause_wd), .csr_mtval_writedata_i(mtval_wd),
    .csr_mip_writedata_i(mip_wd),
    .csr_mstatus_write_valid_i(mstatus_wv), .csr_mepc_write_valid_i(mepc_wv),
    .csr_mcause_write_valid_i(mcause_wv), .csr_mtval_write_valid_i(mtval_wv),
    .csr_mip_write_valid_i(mip_wv),
    .csr_mstatus_readdata_o(mstatus_rd), .csr_mepc_readdata_o(mepc_rd),
    .csr_mtvec_readdata_o(mtvec_rd), .csr_mip_readdata_o(mip_rd),
    .csr_mie_readdata_o(mie_rd),
    .instret_i(instret_i)
  );

  // Reference model: one 64-bit slot per CSR address; aliases and constants resolved on read.
  logic [63:0] mdl [4096];

  function automatic bit is_rw(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'h344, 12'hB00, 12'hB02};
  endfunction

  function automatic bit is_ro(input logic [11:0] a);
    return a inside {12'h301, 12'hC00, 12'hC02, 12'hF14};
  endfunction

  function automatic logic [63:0] mask_of(input logic [11:0] a);
    case (a)
      12'h300:          return 64'h1888;
      12'h304:          return 64'h0888;
      12'h344:          return 64'h0080;
      12'h305, 12'h341: return 64'hFFFF_FFFF_FFFF_FFFC;
      default:          return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] mdl_read(input logic [11:0] a);
    if (a == 12'h301) return 64'h8000_0000_0000_1100;
    if (a == 12'hC00) return mdl[12'hB00];
    if (a == 12'hC02) return mdl[12'hB02];
    if (is_rw(a))     return mdl[a];
    return 64'h0;
  endfunction

  function automatic logic mdl_illegal();
    return (csr_re_i && !(is_rw(csr_raddr_i) || is_ro(csr_raddr_i))) ||
           (csr_we_i && !is_rw(csr_waddr_i));
  endfunction

  // Applied at the clock edge using the inputs the DUT sampled.
  task automatic mdl_step();
    if (rst) begin
      for (int a = 0; a < 4096; a++) mdl[a] = 64'h0;
    end else begin
      mdl[12'hB00] = mdl[12'hB00] + 64'h1;
      if (instret_i) mdl[12'hB02] = mdl[12'hB02] + 64'h1;
      if (csr_we_i && is_rw(csr_waddr_i) && csr_waddr_i != 12'h344)
        mdl[csr_waddr_i] = csr_wdata_i & mask_of(csr_waddr_i);
      if (mstatus_wv) mdl[12'h300] = mstatus_wd & mask_of(12'h300);
      if (mepc_wv)    mdl[12'h341] = mepc_wd & mask_of(12'h341);
      if (mcause_wv)  mdl[12'h342] = mcause_wd;
      if (mtval_wv)   mdl[12'h343] = mtval_wd;
      if (mip_wv)     mdl[12'h344] = mip_wd & mask_of(12'h344);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic idle();
    csr_we_i = 1'b0; csr_re_i = 1'b0; instret_i = 1'b0;
    mstatus_wv = 1'b0; mepc_wv = 1'b0; mcause_wv = 1'b0; mtval_wv = 1'b0; mip_wv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
    csr_raddr_i = 12'h300; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", csr_rdata_o, 64'h0); end
    csr_raddr_i = 12'h301; #1;
    n_checks++; if (csr_rdata_o !== 64'h8000_0000_0000_1100) begin n_fail++; $display("FAIL reset_misa: got %h want %h", csr_rdata_o, 64'h8000_0000_0000_1100); end
    n_checks++; if ({mstatus_rd, mepc_rd, mtvec_rd, mie_rd, mip_rd} !== 320'h0) begin n_fail++; $display("FAIL reset_trap_outputs: mstatus %h mepc %h mtvec %h mie %h mip %h want 0", mstatus_rd, mepc_rd, mtvec_rd, mie_rd, mip_rd); end
    csr_raddr_i = 12'hB00; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_mcycle0: got %h want %h", csr_rdata_o, 64'h0); end
    tick();
    n_checks++; if (csr_rdata_o !== 64'h1) begin n_fail++; $display("FAIL reset_mcycle1: got %h want %h", csr_rdata_o, 64'h1); end
  endtask

  task automatic test_masking();
    csr_we_i = 1'b1; csr_wdata_i = '1; csr_waddr_i = 12'h300; #1;
    n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL mask_mstatus_illegal: got %b want 0", csr_illegal_o); end
    tick();
    csr_waddr_i = 12'h305; tick();
    csr_waddr_i = 12'h304; tick();
    csr_waddr_i = 12'h344; #1;
    n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL mask_mip_illegal: got %b want 0", csr_illegal_o); end
    tick();
    idle();
    csr_raddr_i = 12'h300; #1;
    n_checks++; if (csr_rdata_o !== 64'h1888 || mstatus_rd !== 64'h1888) begin n_fail++; $display("FAIL mask_mstatus: got %h/%h want %h", csr_rdata_o, mstatus_rd, 64'h1888); end
    csr_raddr_i = 12'h305; #1;
    n_checks++; if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFC || mtvec_rd !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL mask_mtvec: got %h/%h want %h", csr_rdata_o, mtvec_rd, 64'hFFFF_FFFF_FFFF_FFFC); end
    n_checks++; if (mie_rd !== 64'h888) begin n_fail++; $display("FAIL mask_mie: got %h want %h", mie_rd, 64'h888); end
    csr_raddr_i = 12'h344; #1;
    n_checks++; if (csr_rdata_o !== 64'h0 || mip_rd !== 64'h0) begin n_fail++; $display("FAIL mask_mip: got %h/%h want 0", csr_rdata_o, mip_rd); end
  endtask

  task automatic test_priority();
    mepc_wv = 1'b1; mepc_wd = 64'h8000_0010;
    csr_we_i = 1'b1; csr_waddr_i = 12'h341; csr_wdata_i = 64'h1234;
    tick();
    mepc_wd = 64'h8000_0017;
    csr_waddr_i = 12'h340; csr_wdata_i = 64'h55;
    csr_raddr_i = 12'h341; #1;
    n_checks++; if (csr_rdata_o !== 64'h8000_0010 || mepc_rd !== 64'h8000_0010) begin n_fail++; $display("FAIL prio_mepc: got %h/%h want %h", csr_rdata_o, mepc_rd, 64'h8000_0010); end
    csr_raddr_i = 12'h340; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL prio_same_cycle_old: got %h want %h", csr_rdata_o, 64'h0); end
    tick();
    idle(); #1;
    n_checks++; if (csr_rdata_o !== 64'h55) begin n_fail++; $display("FAIL prio_mscratch: got %h want %h", csr_rdata_o, 64'h55); end
    n_checks++; if (mepc_rd !== 64'h8000_0014) begin n_fail++; $display("FAIL prio_mepc_align: got %h want %h", mepc_rd, 64'h8000_0014); end
  endtask

  task automatic test_counters();
    csr_we_i = 1'b1; csr_waddr_i = 12'hB00; csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    idle(); csr_raddr_i = 12'hB00; #1;
    n_checks++; if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mcycle_written: got %h want %h", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFE); end
    tick();
    n_checks++; if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mcycle_max: got %h want %h", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF); end
    csr_raddr_i = 12'hC00;
    tick();
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h want %h", csr_rdata_o, 64'h0); end
    for (int i = 0; i < 3; i++) begin
      instret_i = 1'b1; tick();
      instret_i = 1'b0; tick();
    end
    csr_raddr_i = 12'hB02; #1;
    n_checks++; if (csr_rdata_o !== 64'h3) begin n_fail++; $display("FAIL minstret_count: got %h want %h", csr_rdata_o, 64'h3); end
    csr_we_i = 1'b1; csr_waddr_i = 12'hB02; csr_wdata_i = 64'd10; instret_i = 1'b1;
    tick();
    idle(); csr_raddr_i = 12'hC02; #1;
    n_checks++; if (csr_rdata_o !== 64'd10) begin n_fail++; $display("FAIL minstret_write_wins: got %h want %h", csr_rdata_o, 64'd10); end
  endtask

  task automatic test_illegal();
    csr_we_i = 1'b1; csr_waddr_i = 12'hF14; csr_wdata_i = 64'h5; #1;
    n_checks++; if (csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_mhartid_write: got %b want 1", csr_illegal_o); end
    tick();
    csr_waddr_i = 12'h301; #1;
    n_checks++; if (csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_misa_write: got %b want 1", csr_illegal_o); end
    tick();
    idle(); csr_raddr_i = 12'hF14; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL mhartid_zero: got %h want 0", csr_rdata_o); end
    csr_raddr_i = 12'h301; #1;
    n_checks++; if (csr_rdata_o !== 64'h8000_0000_0000_1100) begin n_fail++; $display("FAIL misa_kept: got %h want %h", csr_rdata_o, 64'h8000_0000_0000_1100); end
    csr_re_i = 1'b1; csr_raddr_i = 12'h7C0; #1;
    n_checks++; if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_read: rdata %h illegal %b want 0/1", csr_rdata_o, csr_illegal_o); end
    csr_raddr_i = 12'h342; #1;
    n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL legal_read: got %b want 0", csr_illegal_o); end
    idle();
  endtask

  task automatic test_random();
    logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hC00,
                               12'hC02, 12'hF14, 12'h7C0, 12'h123};
    for (int i = 0; i < 300; i++) begin
      csr_we_i    = ($urandom_range(1) == 1);
      csr_re_i    = ($urandom_range(1) == 1);
      csr_waddr_i = pool[$urandom_range(15)];
      csr_raddr_i = pool[$urandom_range(15)];
      csr_wdata_i = {$urandom, $urandom};
      instret_i   = ($urandom_range(1) == 1);
      mstatus_wv  = ($urandom_range(3) == 0); mstatus_wd = {$urandom, $urandom};
      mepc_wv     = ($urandom_range(3) == 0); mepc_wd    = {$urandom, $urandom};
      mcause_wv   = ($urandom_range(3) == 0); mcause_wd  = {$urandom, $urandom};
      mtval_wv    = ($urandom_range(3) == 0); mtval_wd   = {$urandom, $urandom};
      mip_wv      = ($urandom_range(3) == 0); mip_wd     = {$urandom, $urandom};
      #1;
      n_checks++; if (csr_rdata_o !== mdl_read(csr_raddr_i)) begin n_fail++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", i, csr_raddr_i, csr_rdata_o, mdl_read(csr_raddr_i)); end
      n_checks++; if (csr_illegal_o !== mdl_illegal()) begin n_fail++; $display("FAIL rand_illegal[%0d]: got %b want %b", i, csr_illegal_o, mdl_illegal()); end
      n_checks++;
      if ({mstatus_rd, mepc_rd, mtvec_rd, mip_rd, mie_rd} !==
          {mdl[12'h300], mdl[12'h341], mdl[12'h305], mdl[12'h344], mdl[12'h304]}) begin
        n_fail++;
        $display("FAIL rand_trap_outputs[%0d]: mstatus %h/%h mepc %h/%h mtvec %h/%h mip %h/%h mie %h/%h",
                 i, mstatus_rd, mdl[12'h300], mepc_rd, mdl[12'h341], mtvec_rd, mdl[12'h305],
                 mip_rd, mdl[12'h344], mie_rd, mdl[12'h304]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mid_reset();
    mip_wv = 1'b1; mip_wd = 64'h80; tick();
    mip_wv = 1'b0; #1;
    n_checks++; if (mip_rd !== 64'h80) begin n_fail++; $display("FAIL mip_trap_write: got %h want %h", mip_rd, 64'h80); end
    rst = 1'b1;
    mcause_wv = 1'b1; mcause_wd = 64'h8000_0000_0000_0007;
    mip_wv = 1'b1; mip_wd = 64'h80;
    csr_we_i = 1'b1; csr_waddr_i = 12'h340; csr_wdata_i = 64'hABCD;
    tick();
    rst = 1'b0; idle();
    csr_raddr_i = 12'h342; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL midrst_mcause: got %h want 0", csr_rdata_o); end
    n_checks++; if (mip_rd !== 64'h0) begin n_fail++; $display("FAIL midrst_mip: got %h want 0", mip_rd); end
    csr_raddr_i = 12'h340; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL midrst_mscratch: got %h want 0", csr_rdata_o); end
    csr_raddr_i = 12'hB00; #1;
    n_checks++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL midrst_mcycle: got %h want 0", csr_rdata_o); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mdl[a] = 64'h0;
    #2;
    test_reset();
    test_masking();
    test_priority();
    test_counters();
    test_illegal();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
